// File: rtl/stopwatch_bcd_counter.sv
// MM:SS BCD stopwatch driven by rising edges of the 1 Hz divider output, with start/pause/clear control.
// Optional lap hold on the digit outputs is built when STOPWATCH_LAP_EN is defined.
module stopwatch_bcd_counter #(
  parameter int SEC_MOD = 60,
  parameter int MIN_MOD = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_1hz,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       wrap
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam logic [3:0] SEC_O_MAX = 4'((SEC_MOD - 1) % 10);
  localparam logic [3:0] SEC_T_MAX = 4'((SEC_MOD - 1) / 10);
  localparam logic [3:0] MIN_O_MAX = 4'((MIN_MOD - 1) % 10);
  localparam logic [3:0] MIN_T_MAX = 4'((MIN_MOD - 1) / 10);

  state_t     state, state_nx;
  logic       clk_1hz_q, tick, count_en, clear_ok;
  logic [3:0] s_o, s_t, m_o, m_t;
  logic       sec_last, min_last;

  assign tick     = clk_1hz & ~clk_1hz_q;
  assign sec_last = (s_t == SEC_T_MAX) && (s_o == SEC_O_MAX);
  assign min_last = (m_t == MIN_T_MAX) && (m_o == MIN_O_MAX);

  // NOTE: reset is tested inside a posedge-clk-only block, so it is synchronous to clk.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Clear is honoured only outside RUN and beats a simultaneous start_stop.
  always_comb begin
    state_nx = state;
    clear_ok = clear && (state != RUN);
    if (clear_ok)        state_nx = IDLE;
    else if (start_stop) state_nx = (state == RUN) ? PAUSE : RUN;
  end

  always_comb begin
    running  = (state == RUN);
    count_en = (state == RUN) && tick;
  end

  // NOTE: all sequential state uses non-blocking assignments; blocking here would race other always_ff blocks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_1hz_q <= 1'b0;
      wrap      <= 1'b0;
      s_o <= '0; s_t <= '0; m_o <= '0; m_t <= '0;
    end else begin
      clk_1hz_q <= clk_1hz;
      wrap      <= 1'b0;
      if (clear_ok) begin
        s_o <= '0; s_t <= '0; m_o <= '0; m_t <= '0;
      end else if (count_en) begin
        if (sec_last) begin
          s_o <= '0;
          s_t <= '0;
          if (min_last) begin
            m_o  <= '0;
            m_t  <= '0;
            wrap <= 1'b1;
          end else if (m_o == 4'd9) begin
            m_o <= '0;
            m_t <= m_t + 4'd1;
          end else begin
            m_o <= m_o + 4'd1;
          end
        end else if (s_o == 4'd9) begin
          s_o <= '0;
          s_t <= s_t + 4'd1;
        end else begin
          s_o <= s_o + 4'd1;
        end
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic        hold;
  logic [15:0] snap;

  // The snapshot takes the digits present before any increment on the lap edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold <= 1'b0;
      snap <= '0;
    end else if (clear_ok) begin
      hold <= 1'b0;
    end else if (lap && (state != IDLE)) begin
      hold <= ~hold;
      if (!hold) snap <= {m_t, m_o, s_t, s_o};
    end
  end

  always_comb begin
    {min_tens, min_ones, sec_tens, sec_ones} = {m_t, m_o, s_t, s_o};
    if (hold) {min_tens, min_ones, sec_tens, sec_ones} = snap;
  end
`else
  logic lap_unused;
  assign lap_unused = lap;

  always_comb begin
    {min_tens, min_ones, sec_tens, sec_ones} = {m_t, m_o, s_t, s_o};
  end
`endif

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Bench for stopwatch_bcd_counter: directed scenarios then random stimulus, checked every cycle against
// a model that keeps the elapsed time as a plain integer number of seconds.
module tb_stopwatch_bcd_counter;

  localparam int SEC_MOD = 60;
  localparam int MIN_MOD = 60;

  logic       clk = 1'b0;
  logic       rst, clk_1hz, start_stop, clear, lap;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       running, wrap;

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0 idle, 1 run, 2 pause; count is total seconds.
  int m_mode  = 0;
  int m_count = 0;
  bit m_hz_q  = 1'b0;
  bit m_wrap  = 1'b0;
  bit m_hold  = 1'b0;
  int m_held  = 0;

  stopwatch_bcd_counter #(.SEC_MOD(SEC_MOD), .MIN_MOD(MIN_MOD)) dut (
    .clk(clk), .rst(rst), .clk_1hz(clk_1hz), .start_stop(start_stop), .clear(clear), .lap(lap),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
    .running(running), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_digits(input int secs);
    int s, m;
    s = secs % SEC_MOD;
    m = secs / SEC_MOD;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model_edge(input bit r, input bit ss, input bit cl, input bit lp, input bit hz);
    bit tick, clear_ok;
    int old;
    if (!r) begin
      m_mode = 0; m_count = 0; m_hz_q = 0; m_wrap = 0; m_hold = 0;
      return;
    end
    tick   = hz && !m_hz_q;
    m_hz_q = hz;
    m_wrap = 0;
    old    = m_count;
    if (m_mode == 1 && tick) begin
      m_count++;
      if (m_count == SEC_MOD * MIN_MOD) begin
        m_count = 0;
        m_wrap  = 1;
      end
    end
    clear_ok = cl && (m_mode != 1);
`ifdef STOPWATCH_LAP_EN
    if (clear_ok) m_hold = 0;
    else if (lp && m_mode != 0) begin
      if (!m_hold) m_held = old;
      m_hold = !m_hold;
    end
`endif
    if (clear_ok) begin
      m_mode  = 0;
      m_count = 0;
    end else if (ss) begin
      m_mode = (m_mode == 1) ? 2 : 1;
    end
  endtask

  task automatic step(input bit r, input bit ss, input bit cl, input bit lp, input bit hz);
    @(negedge clk);
    rst = r; start_stop = ss; clear = cl; lap = lp; clk_1hz = hz;
    @(posedge clk);
    model_edge(r, ss, cl, lp, hz);
    #1;
    check("digits", 32'({min_tens, min_ones, sec_tens, sec_ones}),
          32'(to_digits(m_hold ? m_held : m_count)));
    check("running", 32'(running), 32'(m_mode == 1));
    check("wrap", 32'(wrap), 32'(m_wrap));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0);
    end
  endtask

  initial begin
    rst = 1'b0; clk_1hz = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;

    // Reset, then a toggling divider with no start leaves 00:00.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1'(i));
    ticks(5);

    // Start, five seconds, then on through 59:59 to the wrap, then to 12:34.
    step(1, 1, 0, 0, 0);
    ticks(5);
    ticks(SEC_MOD * MIN_MOD - 5);
    ticks(12 * 60 + 34);

    // Reset mid-run with a rising divider edge on the same clock.
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);

    // Stop coinciding with a tick at 00:07, hold in pause, clear; clear ignored while running.
    step(1, 1, 0, 0, 0);
    ticks(7);
    step(1, 1, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    ticks(3);
    step(1, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    ticks(3);
    step(1, 0, 1, 0, 0);
    ticks(2);

    // Lap hold around four seconds, released by a second lap pulse.
    step(1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    ticks(10);
    step(1, 0, 0, 1, 0);
    ticks(4);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);

    // Random control pulses, divider level and occasional reset.
    for (int i = 0; i < 6000; i++) begin
      step($urandom_range(399, 0) != 0,
           $urandom_range(24, 0) == 0,
           $urandom_range(29, 0) == 0,
           $urandom_range(19, 0) == 0,
           1'($urandom_range(1, 0)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
